// File: rtl/vga_pkg.sv
// Shared timing defaults, axis segment enum and pattern width
// for the VGA timing controller and pattern scheduler.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned PATTERN_W = 3;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } axis_state_t;

  function automatic int unsigned axis_total(
    input int unsigned a,
    input int unsigned f,
    input int unsigned s,
    input int unsigned b
  );
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/vga_timing_sched_if.sv
// Bundle between the timing scheduler and the pixel datapath:
// control inputs plus raster position, sync and pattern outputs.
interface vga_timing_sched_if;
  import vga_pkg::*;

  logic                 ena;
  logic [PATTERN_W-1:0] mode_in;
  logic                 auto_en;
  logic [9:0]           hpos;
  logic [9:0]           vpos;
  logic                 hsync;
  logic                 vsync;
  logic                 display_on;
  logic                 frame_start;
  logic [PATTERN_W-1:0] pattern_sel;
  logic [7:0]           frame_count;

  modport master (
    input  ena,
    input  mode_in,
    input  auto_en,
    output hpos,
    output vpos,
    output hsync,
    output vsync,
    output display_on,
    output frame_start,
    output pattern_sel,
    output frame_count
  );

  modport slave (
    output ena,
    output mode_in,
    output auto_en,
    input  hpos,
    input  vpos,
    input  hsync,
    input  vsync,
    input  display_on,
    input  frame_start,
    input  pattern_sel,
    input  frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus segment state machine
// (ACTIVE -> FRONT -> SYNC -> BACK) kept in lock-step with it.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned SEG_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned SEG_FRONT  = DEF_H_FRONT,
  parameter int unsigned SEG_SYNC   = DEF_H_SYNC,
  parameter int unsigned SEG_BACK   = DEF_H_BACK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [9:0]  pos,
  output axis_state_t state,
  output axis_state_t state_nxt,
  output logic        wrap
);

  localparam int unsigned TOTAL =
    axis_total(SEG_ACTIVE, SEG_FRONT, SEG_SYNC, SEG_BACK);

  localparam logic [9:0] END_ACT = 10'(SEG_ACTIVE - 1);
  localparam logic [9:0] END_FRT = 10'(SEG_ACTIVE + SEG_FRONT - 1);
  localparam logic [9:0] END_SYN =
    10'(SEG_ACTIVE + SEG_FRONT + SEG_SYNC - 1);
  localparam logic [9:0] END_ALL = 10'(TOTAL - 1);

  // Segment of the position that the next step will load.
  always_comb begin
    wrap      = step && (pos == END_ALL);
    state_nxt = state;
    if (step) begin
      unique case (state)
        ACTIVE: if (pos == END_ACT) state_nxt = FRONT;
        FRONT:  if (pos == END_FRT) state_nxt = SYNC;
        SYNC:   if (pos == END_SYN) state_nxt = BACK;
        BACK:   if (pos == END_ALL) state_nxt = ACTIVE;
        default: state_nxt = ACTIVE;
      endcase
    end
  end

  // Position and segment registers advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      state <= ACTIVE;
    end else begin
      if (wrap) begin
        pos <= '0;
      end else if (step) begin
        pos <= pos + 10'd1;
      end
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_sched.sv
// 640x480@60 raster generator with frame-aligned test-pattern
// scheduling (manual select or automatic frame-paced cycling).
module vga_timing_sched
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned AUTO_FRAMES = 60
) (
  input logic clk,
  input logic rst_n,
  vga_timing_sched_if.master bus
);

  localparam logic [7:0] AF_LAST = 8'(AUTO_FRAMES - 1);
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;
  localparam logic [PATTERN_W-1:0] PAT_ONE = 1;

  logic [9:0]  hpos;
  logic [9:0]  vpos;
  axis_state_t h_state;
  axis_state_t h_nxt;
  axis_state_t v_state;
  axis_state_t v_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic        v_step;
  logic        frame_edge;

  logic                 hsync;
  logic                 vsync;
  logic                 display_on;
  logic                 frame_start;
  logic [PATTERN_W-1:0] pattern_sel;
  logic [7:0]           frame_count;
  logic [7:0]           auto_cnt;

  vga_axis_counter #(
    .SEG_ACTIVE (H_ACTIVE),
    .SEG_FRONT  (H_FRONT),
    .SEG_SYNC   (H_SYNC),
    .SEG_BACK   (H_BACK)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (bus.ena),
    .pos       (hpos),
    .state     (h_state),
    .state_nxt (h_nxt),
    .wrap      (h_wrap)
  );

  assign v_step = h_wrap & bus.ena;

  vga_axis_counter #(
    .SEG_ACTIVE (V_ACTIVE),
    .SEG_FRONT  (V_FRONT),
    .SEG_SYNC   (V_SYNC),
    .SEG_BACK   (V_BACK)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (v_step),
    .pos       (vpos),
    .state     (v_state),
    .state_nxt (v_nxt),
    .wrap      (v_wrap)
  );

  // A frame wrap can only come out of BACK on both axes.
  assign frame_edge = v_wrap
                   && (h_state == BACK)
                   && (v_state == BACK);

  // Sync/enable decode registered from the upcoming segment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      display_on  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (bus.ena) begin
        hsync <= (h_nxt == SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
        vsync <= (v_nxt == SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
        display_on <= (h_nxt == ACTIVE) && (v_nxt == ACTIVE);
      end
    end
  end

  // Pattern choice and frame bookkeeping, only at frame wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_sel <= '0;
      frame_count <= '0;
      auto_cnt    <= '0;
    end else if (frame_edge) begin
      frame_count <= frame_count + 8'd1;
      if (!bus.auto_en) begin
        pattern_sel <= bus.mode_in;
        auto_cnt    <= '0;
      end else if (auto_cnt == AF_LAST) begin
        pattern_sel <= pattern_sel + PAT_ONE;
        auto_cnt    <= '0;
      end else begin
        auto_cnt <= auto_cnt + 8'd1;
      end
    end
  end

  assign bus.hpos        = hpos;
  assign bus.vpos        = vpos;
  assign bus.hsync       = hsync;
  assign bus.vsync       = vsync;
  assign bus.display_on  = display_on;
  assign bus.frame_start = frame_start;
  assign bus.pattern_sel = pattern_sel;
  assign bus.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_sched.sv
// Bench for vga_timing_sched on a shrunken raster (30x15) so
// many frames fit; a cycle-count model predicts every output.
module tb_vga_timing_sched;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int AF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_timing_sched_if bus();

  vga_timing_sched #(
    .H_ACTIVE    (HA),
    .H_FRONT     (HF),
    .H_SYNC      (HS),
    .H_BACK      (HB),
    .V_ACTIVE    (VA),
    .V_FRONT     (VF),
    .V_SYNC      (VS),
    .V_BACK      (VB),
    .SYNC_ACTIVE (1'b0),
    .AUTO_FRAMES (AF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit go = 0;

  // model: n = enabled edges since reset
  int n = 0;
  int mfc = 0;
  int mpat = 0;
  int mafc = 0;
  bit mfs = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0; mfc = 0; mpat = 0; mafc = 0; mfs = 0;
    end else if (bus.ena) begin
      n++;
      mfs = (n % FT) == 0;
      if (mfs) begin
        mfc = (mfc + 1) % 256;
        if (!bus.auto_en) begin
          mpat = int'(bus.mode_in);
          mafc = 0;
        end else if (mafc == AF - 1) begin
          mafc = 0;
          mpat = (mpat + 1) % 8;
        end else begin
          mafc++;
        end
      end
    end else begin
      mfs = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (go) begin
      int h, v;
      h = n % HT;
      v = (n / HT) % VT;
      chk("hpos", int'(bus.hpos), h);
      chk("vpos", int'(bus.vpos), v);
      chk("display_on", int'(bus.display_on),
          int'(n != 0 && h < HA && v < VA));
      chk("hsync", int'(bus.hsync),
          int'(!(h >= HA + HF && h < HA + HF + HS)));
      chk("vsync", int'(bus.vsync),
          int'(!(v >= VA + VF && v < VA + VF + VS)));
      chk("frame_start", int'(bus.frame_start), int'(mfs));
      chk("pattern_sel", int'(bus.pattern_sel), mpat);
      chk("frame_count", int'(bus.frame_count), mfc);
    end
  end

  task automatic wait_fs(input string nm);
    bit seen = 0;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_start;
    end
    chk(nm, int'(seen), 1);
  endtask

  initial begin
    int lowcnt;
    bit found;
    bit seenfs;
    bus.ena = 1'b0;
    bus.mode_in = '0;
    bus.auto_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    go = 1;
    chk("rst_hpos", int'(bus.hpos), 0);
    chk("rst_hsync", int'(bus.hsync), 1);
    chk("rst_disp", int'(bus.display_on), 0);
    bus.ena = 1'b1;
    rst_n = 1'b1;

    lowcnt = 0;
    for (int i = 0; i < HT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("first_hpos", int'(bus.hpos), 1);
        chk("first_disp", int'(bus.display_on), 1);
      end
      if (!bus.hsync) lowcnt++;
    end
    chk("hsync_low_cycles", lowcnt, HS);
    chk("line_hpos", int'(bus.hpos), 0);
    chk("line_vpos", int'(bus.vpos), 1);

    wait_fs("fs1");
    chk("fs1_hpos", int'(bus.hpos), 0);
    chk("fs1_vpos", int'(bus.vpos), 0);
    chk("fs1_count", int'(bus.frame_count), 1);

    repeat (150) @(negedge clk);
    bus.mode_in = 3'd5;
    repeat (50) @(negedge clk);
    chk("pat_hold0", int'(bus.pattern_sel), 0);
    wait_fs("fs2");
    chk("pat5", int'(bus.pattern_sel), 5);
    repeat (100) @(negedge clk);
    bus.mode_in = 3'd2;
    repeat (100) @(negedge clk);
    chk("pat_hold5", int'(bus.pattern_sel), 5);
    wait_fs("fs3");
    chk("pat2", int'(bus.pattern_sel), 2);

    repeat (100) @(negedge clk);
    bus.auto_en = 1'b1;
    bus.mode_in = 3'd6;
    wait_fs("auto1");
    chk("auto1_pat", int'(bus.pattern_sel), 2);
    wait_fs("auto2");
    chk("auto2_pat", int'(bus.pattern_sel), 3);
    for (int k = 3; k <= 10; k++) wait_fs("autok");
    chk("auto10_pat", int'(bus.pattern_sel), 7);
    wait_fs("auto11");
    wait_fs("auto12");
    chk("auto12_wrap", int'(bus.pattern_sel), 0);

    bus.auto_en = 1'b0;
    found = 0;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      @(negedge clk);
      found = (bus.hpos == 10'd22);
    end
    chk("find_h22", int'(found), 1);
    bus.ena = 1'b0;
    seenfs = 0;
    repeat (50) begin
      @(negedge clk);
      seenfs |= bus.frame_start;
    end
    chk("frz_hpos", int'(bus.hpos), 22);
    chk("frz_hsync", int'(bus.hsync), 0);
    chk("frz_fs", int'(seenfs), 0);
    bus.ena = 1'b1;
    @(negedge clk);
    chk("resume_hpos", int'(bus.hpos), 23);

    repeat (FT) @(negedge clk);
    chk("pre_rst_pat", int'(bus.pattern_sel), 6);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hpos", int'(bus.hpos), 0);
    chk("arst_vpos", int'(bus.vpos), 0);
    chk("arst_pat", int'(bus.pattern_sel), 0);
    chk("arst_fc", int'(bus.frame_count), 0);
    chk("arst_hsync", int'(bus.hsync), 1);
    chk("arst_disp", int'(bus.display_on), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_hpos", int'(bus.hpos), 1);
    chk("rel_pat", int'(bus.pattern_sel), 0);

    bus.auto_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      bus.ena = ($urandom_range(7) != 0);
      bus.mode_in = 3'($urandom_range(7));
      if ($urandom_range(199) == 0) bus.auto_en = ~bus.auto_en;
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_sched.md
Name: vga_timing_sched

Overview:
- Timing controller and pattern scheduler for the VGA checkerboard test top `tt_um_vga_example`.
- Generates the 640x480@60 raster: pixel/line counters, hsync, vsync and display_on.
- Chooses which test pattern the pixel datapath renders, switching only on frame boundaries.
- Pattern selection comes from user inputs or from automatic frame-paced cycling.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
AUTO_FRAMES, 60, frames per pattern in auto mode (range 1..256)

Ports:
clk  input  1  pixel clock (25.175 MHz nominal)
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
mode_in  input  3  requested pattern when auto_en=0
auto_en  input  1  1 = cycle patterns automatically
hpos  output  10  current pixel column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per SYNC_ACTIVE
vsync  output  1  vertical sync, level per SYNC_ACTIVE
display_on  output  1  1 inside the visible region
frame_start  output  1  one-cycle pulse at (0,0)
pattern_sel  output  3  pattern index for the pixel datapath
frame_count  output  8  free-running frame counter, wraps at 256

Behaviour:
- Derived totals: H_TOTAL = sum of the four H segments (800). V_TOTAL = sum of the four V segments (525).
- All outputs are registered and are cleared asynchronously on rst_n low.
- Reset values:
  - hpos=0, vpos=0
  - hsync and vsync = inactive level (~SYNC_ACTIVE)
  - display_on=0, frame_start=0
  - pattern_sel=0, frame_count=0
  - auto-frame counter=0
- Counter advance: on each clk edge with ena=1, hpos increments. When hpos=H_TOTAL-1 it wraps to 0 and vpos increments. When vpos=V_TOTAL-1 at that wrap, vpos also wraps to 0.
- ena=0: every register holds its value, including the sync levels. No pulses are generated while ena=0.
- Sync and enable decode is computed from the next counter values, so it is aligned with hpos/vpos in the same cycle:
  - display_on = (hpos<H_ACTIVE) && (vpos<V_ACTIVE)
  - hsync is asserted for H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751
  - vsync is asserted for V_ACTIVE+V_FRONT <= vpos < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491. It spans whole lines.
- Reset exception: the first (0,0) after reset has display_on=0. The first clock edge brings hpos to 1 with display_on=1.
- frame_start pulses for exactly one cycle, on the cycle the counters reach (0,0) through a wrap. It never pulses on reset release.
- Per-axis state machine: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Transitions happen at the segment-end counts. The state register is internal and must stay consistent with the counter at all times.
- Pattern scheduling takes effect only on the edge that produces frame_start:
  - frame_count increments on that edge.
  - auto_en=0: pattern_sel <= mode_in sampled on that edge. The auto-frame counter is cleared to 0.
  - auto_en=1: if the auto-frame counter = AUTO_FRAMES-1, it is cleared and pattern_sel <= pattern_sel+1 mod 8. Otherwise the counter increments.
- mode_in and auto_en changes mid-frame have no effect until the next frame_start edge.
- Reset mid-frame: immediate return to the reset values. The raster restarts at (0,0).

Decomposition:
- Package vga_pkg:
  - default timing constants and the H_TOTAL/V_TOTAL derivation function
  - axis state enum {ACTIVE, FRONT, SYNC, BACK}
  - PATTERN_W=3
- Sub-module vga_axis_counter, instantiated once for H and once for V:
  - parameterised by the four segment lengths
  - inputs: clk, rst_n, step
  - outputs: pos, state, wrap (combinational on the last count with step=1)
- The V instance's step input is the H instance's wrap, gated by ena.

Test Plan:
- Reset then ena=1 for 800 cycles -> hpos runs 1..799,0. hsync=0 exactly for hpos 656..751 (96 cycles). display_on falls at hpos=640. vpos=1 after the wrap.
- Run one full frame of 420000 cycles -> exactly one frame_start pulse at (0,0) and frame_count=1. vsync=0 for lines 490..491 only (1600 cycles).
- auto_en=0: drive mode_in=5 at (100,100) -> pattern_sel stays 0 until the frame_start edge, then becomes 5. Change mode_in to 2 mid-frame -> no change before the next frame_start.
- AUTO_FRAMES=2, auto_en=1, run 6 frames -> pattern_sel steps 0,0,1,1,2,2,3 at successive frame_starts. At pattern_sel=7 it wraps to 0.
- ena low for 50 cycles at hpos=700 (hsync asserted) -> hpos, vpos and hsync are frozen. There is no frame_start. Counting resumes at 701 when ena returns high.
- Assert rst_n at (300,200) for 3 cycles -> all outputs take their reset values immediately (asynchronous). After release, hpos counts from 1 and pattern_sel=0.
